// File: rtl/pe_bus_pkg.sv
// Shared types and width helpers for the PE bus master: FSM states and
// request-entry / occupancy width calculations.
package pe_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_RESP
    } state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_REG_AW  = 5;
    localparam int DEF_QDEPTH  = 4;
    localparam int DEF_TIMEOUT = 15;

    // Queued entry layout is {write, rd, addr, wdata}.
    function automatic int entry_width(input int addr_w, input int data_w, input int reg_aw);
        return 1 + reg_aw + addr_w + data_w;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pe_req_fifo.sv
// Synchronous request FIFO with a combinational head view; full refuses
// pushes even when a pop happens in the same cycle.
module pe_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pe_bus_interface.sv
// Queued bus master for one CGRA PE: buffers core requests, wins the shared
// bus, runs one memory transfer at a time with an ack timeout.
module pe_bus_interface
    import pe_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int QDEPTH  = DEF_QDEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_write_i,
    input  logic [ADDR_W-1:0]              req_addr_i,
    input  logic [DATA_W-1:0]              req_wdata_i,
    input  logic [REG_AW-1:0]              req_rd_i,
    output logic                           rsp_valid_o,
    output logic                           rsp_write_o,
    output logic [DATA_W-1:0]              rsp_rdata_o,
    output logic [REG_AW-1:0]              rsp_rd_o,
    output logic                           rsp_err_o,
    output logic                           bus_request_o,
    input  logic                           grant_i,
    output logic [ADDR_W-1:0]              mem_address_o,
    output logic                           mem_read_o,
    output logic                           mem_write_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic                           mem_ack_i,
    input  logic [DATA_W-1:0]              mem_rdata_i,
    output logic                           busy_o,
    output logic [count_width(QDEPTH)-1:0] q_count_o
);
    localparam int EW = entry_width(ADDR_W, DATA_W, REG_AW);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              write;
        logic [REG_AW-1:0] rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t            push_entry, head;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    state_e            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              in_xfer, in_resp;

    assign push_entry = '{write: req_write_i, rd: req_rd_i, addr: req_addr_i, wdata: req_wdata_i};
    assign req_ready_o = !fifo_full;
    assign fifo_push   = req_valid_i && req_ready_o;
    assign fifo_pop    = (state_q == ST_RESP);

    pe_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .count_o (q_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cnt_inc = cnt_q + TW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
            ST_REQ: begin
                cnt_d = '0;
                if (grant_i) state_d = ST_XFER;
            end
            ST_XFER: begin
                // Ack beats both grant loss and timeout in the same cycle.
                if (mem_ack_i) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = head.write ? '0 : mem_rdata_i;
                end else if (!grant_i) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else if (cnt_inc == TW'(TIMEOUT)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode only flops, so an async reset clears them immediately.
    assign in_xfer       = (state_q == ST_XFER);
    assign in_resp       = (state_q == ST_RESP);
    assign bus_request_o = (state_q == ST_REQ) || in_xfer;
    assign mem_read_o    = in_xfer && !head.write;
    assign mem_write_o   = in_xfer && head.write;
    assign mem_address_o = in_xfer ? head.addr  : '0;
    assign mem_wdata_o   = in_xfer ? head.wdata : '0;
    assign rsp_valid_o   = in_resp;
    assign rsp_write_o   = in_resp && head.write;
    assign rsp_rd_o      = in_resp ? head.rd : '0;
    assign rsp_rdata_o   = in_resp ? rdata_q : '0;
    assign rsp_err_o     = in_resp && err_q;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pe_bus_interface.sv
// Bench for pe_bus_interface: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_pe_bus_interface;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int REG_AW  = 5;
    localparam int QDEPTH  = 4;
    localparam int TIMEOUT = 15;
    localparam int CW      = $clog2(QDEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [REG_AW-1:0] req_rd = '0;
    logic              rsp_valid, rsp_write, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [REG_AW-1:0] rsp_rd;
    logic              bus_request, grant = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read, mem_write, mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_wdata, mem_rdata = '0;
    logic              busy;
    logic [CW-1:0]     q_count;

    always #5 clk = ~clk;

    pe_bus_interface #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_AW (REG_AW),
        .QDEPTH (QDEPTH), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n),
        .req_valid_i (req_valid), .req_ready_o (req_ready), .req_write_i (req_write),
        .req_addr_i (req_addr), .req_wdata_i (req_wdata), .req_rd_i (req_rd),
        .rsp_valid_o (rsp_valid), .rsp_write_o (rsp_write), .rsp_rdata_o (rsp_rdata),
        .rsp_rd_o (rsp_rd), .rsp_err_o (rsp_err),
        .bus_request_o (bus_request), .grant_i (grant),
        .mem_address_o (mem_address), .mem_read_o (mem_read), .mem_write_o (mem_write),
        .mem_wdata_o (mem_wdata), .mem_ack_i (mem_ack), .mem_rdata_i (mem_rdata),
        .busy_o (busy), .q_count_o (q_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending requests plus the phase of the
    // transaction at the queue head (0 waiting, 1 requesting, 2 transferring, 3 responding).
    typedef struct {
        logic              write;
        logic [REG_AW-1:0] rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ent_t;

    ent_t              mq[$];
    int                ph = 0;
    int                xc = 0;
    logic              m_err = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;

    initial forever begin
        bit   do_push;
        ent_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            ph = 0; xc = 0; m_err = 1'b0; m_rdata = '0;
        end else begin
            do_push = req_valid && (mq.size() < QDEPTH);
            e = '{req_write, req_rd, req_addr, req_wdata};
            case (ph)
                0: if (mq.size() > 0) ph = 1;
                1: if (grant) begin ph = 2; xc = 0; end
                2: begin
                    xc++;
                    if (mem_ack) begin
                        ph = 3; m_err = 1'b0;
                        m_rdata = mq[0].write ? '0 : mem_rdata;
                    end else if (!grant) begin
                        ph = 1;
                    end else if (xc == TIMEOUT) begin
                        ph = 3; m_err = 1'b1; m_rdata = '0;
                    end
                end
                default: begin
                    void'(mq.pop_front());
                    ph = 0;
                end
            endcase
            if (do_push) mq.push_back(e);
        end
    end

    initial forever begin
        ent_t h;
        @(negedge clk);
        h = '{1'b0, '0, '0, '0};
        if (mq.size() > 0) h = mq[0];
        chk("bus_request", bus_request, (ph == 1 || ph == 2));
        chk("mem_read",    mem_read,    (ph == 2) && !h.write);
        chk("mem_write",   mem_write,   (ph == 2) && h.write);
        chk("mem_address", mem_address, (ph == 2) ? h.addr : '0);
        chk("mem_wdata",   mem_wdata,   (ph == 2) ? h.wdata : '0);
        chk("rsp_valid",   rsp_valid,   (ph == 3));
        chk("rsp_write",   rsp_write,   (ph == 3) && h.write);
        chk("rsp_rd",      rsp_rd,      (ph == 3) ? h.rd : '0);
        chk("rsp_rdata",   rsp_rdata,   (ph == 3) ? m_rdata : '0);
        chk("rsp_err",     rsp_err,     (ph == 3) && m_err);
        chk("q_count",     q_count,     mq.size());
        chk("req_ready",   req_ready,   mq.size() < QDEPTH);
        chk("busy",        busy,        (ph != 0) || (mq.size() > 0));
        if (rsp_valid)
            $display("rsp rd=%0d write=%0b rdata=%h err=%0b t=%0t", rsp_rd, rsp_write, rsp_rdata, rsp_err, $time);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [REG_AW-1:0] r);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_rd = r;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_read(input string name);
        int n = 0;
        while (!mem_read && n < 20) begin step(); n++; end
        chk(name, mem_read, 1'b1);
    endtask

    initial begin
        int n, xcyc;
        bit seen_err, got2;

        // Reset state
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_q_count", q_count, 0);
        chk("rst_bus_request", bus_request, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: load
        grant = 1'b1;
        push1(1'b0, 32'h100, 32'h0, 5'd3);
        chk("t1_qcount", q_count, 1);
        step();
        chk("t1_bus_request", bus_request, 1'b1);
        step();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_addr", mem_address, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h87654321;
        step();
        mem_ack = 1'b0;
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rdata", rsp_rdata, 32'h87654321);
        chk("t1_rd", rsp_rd, 3);
        chk("t1_err", rsp_err, 1'b0);
        step();
        chk("t1_pulse", rsp_valid, 1'b0);

        // 2: store
        push1(1'b1, 32'h2BB8, 32'h11111111, 5'd4);
        step(); step();
        chk("t2_mem_write", mem_write, 1'b1);
        chk("t2_mem_read", mem_read, 1'b0);
        chk("t2_wdata", mem_wdata, 32'h11111111);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("t2_rsp_write", rsp_write, 1'b1);
        chk("t2_rdata_zero", rsp_rdata, 0);
        step();

        // 3: full queue
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300 + 32'(i * 4); req_rd = 5'(i);
            step();
        end
        req_valid = 1'b0;
        chk("t3_q_count", q_count, 4);
        chk("t3_req_ready", req_ready, 1'b0);
        grant = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5A5A0000;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (rsp_valid) begin
                chk("t3_order", rsp_rd, n);
                n++;
            end
        end
        mem_ack = 1'b0;
        chk("t3_rsp_count", n, 4);
        chk("t3_drained", busy, 1'b0);

        // 4: timeout then next entry
        push1(1'b0, 32'h400, 32'h0, 5'd7);
        push1(1'b0, 32'h404, 32'h0, 5'd8);
        xcyc = 0; seen_err = 0; got2 = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (!seen_err) begin
                if (mem_read) xcyc++;
                if (rsp_valid) begin
                    seen_err = 1;
                    chk("t4_err", rsp_err, 1'b1);
                    chk("t4_rd", rsp_rd, 7);
                    chk("t4_xfer_cycles", xcyc, 15);
                    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
                end
            end else if (rsp_valid && !got2) begin
                got2 = 1;
                chk("t4_next_rd", rsp_rd, 8);
                chk("t4_next_err", rsp_err, 1'b0);
                chk("t4_next_rdata", rsp_rdata, 32'hCAFE0001);
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;
        chk("t4_done", got2, 1'b1);

        // 5: grant loss mid-transfer
        push1(1'b0, 32'h500, 32'h0, 5'd9);
        wait_read("t5_first_xfer");
        step();
        grant = 1'b0;
        step();
        chk("t5_strobe_low", mem_read, 1'b0);
        chk("t5_back_to_req", bus_request, 1'b1);
        step();
        grant = 1'b1;
        step();
        chk("t5_regrant", mem_read, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h00C0FFEE;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            mem_ack = 1'b0;
            if (rsp_valid) begin
                n++;
                chk("t5_rdata", rsp_rdata, 32'h00C0FFEE);
            end
        end
        chk("t5_single_rsp", n, 1);

        // 6: async reset mid-transfer
        push1(1'b0, 32'h600, 32'h0, 5'd10);
        push1(1'b1, 32'h604, 32'h1, 5'd11);
        push1(1'b0, 32'h608, 32'h2, 5'd12);
        wait_read("t6_xfer");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mem_read", mem_read, 1'b0);
        chk("t6_bus_request", bus_request, 1'b0);
        chk("t6_q_count", q_count, 0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_req_ready", req_ready, 1'b1);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("t6_idle_after", busy, 1'b0);

        // Randomized traffic: normal mix, then rare acks to exercise timeouts
        for (int seg = 0; seg < 2; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                req_valid = ($urandom_range(0, 1) == 1);
                req_write = ($urandom_range(0, 1) == 1);
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_rd    = 5'($urandom_range(0, 31));
                grant     = ($urandom_range(0, 99) < (seg == 0 ? 75 : 97));
                mem_ack   = ($urandom_range(0, 99) < (seg == 0 ? 30 : 4));
                mem_rdata = $urandom;
                if (seg == 0 && c == 700) begin
                    #2 rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end else begin
                    step();
                end
            end
        end

        req_valid = 1'b0; grant = 1'b0; mem_ack = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
